// File: rtl/tt_sweep_pkg.sv
// Shared state type and sizing/counting helpers for the truth-table sweeper.
package tt_sweep_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} stateT;

    // Wide enough for the worst case of every channel failing on every vector.
    function automatic int errWidth(input int nIn, input int nCh);
        return nIn + $clog2(nCh) + 1;
    endfunction

    function automatic logic [4:0] popcount(input logic [15:0] bits);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + {4'd0, bits[i]};
        return n;
    endfunction

endpackage

// File: rtl/tt_sweep_seq.sv
// Vector sequencer: index counter, settle countdown and index-to-vector coding.
// TT_SWEEP_GRAY_EN selects Gray-coded vector order instead of binary.
module tt_sweep_seq #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init,
    input  logic            adv,
    input  logic            dec,
    output logic [N_IN-1:0] vec,
    output logic            settled,
    output logic            last
);

    localparam logic [N_IN-1:0] ONE        = 1;
    localparam logic [7:0]      SETTLE_CNT = 8'(SETTLE);

    logic [N_IN-1:0] idx, idxNext;
    logic [7:0]      cnt;

    function automatic logic [N_IN-1:0] code(input logic [N_IN-1:0] i);
`ifdef TT_SWEEP_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    assign idxNext = idx + ONE;
    assign settled = (cnt == 8'd0);
    assign last    = &idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            vec <= '0;
            cnt <= '0;
        end else if (init) begin
            idx <= '0;
            vec <= code('0);
            cnt <= SETTLE_CNT;
        end else if (adv) begin
            idx <= idxNext;
            vec <= code(idxNext);
            cnt <= SETTLE_CNT;
        end else if (dec) begin
            cnt <= cnt - 8'd1;
        end
    end

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper: drives every input vector, compares DUT outputs
// against an expected table. TT_SWEEP_GRAY_EN switches the sweep to Gray order.
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_CH   = 4,
    parameter int SETTLE = 1,
    localparam int VECS  = 1 << N_IN,
    localparam int ERRW  = errWidth(N_IN, N_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_CH*VECS-1:0] exp_tt,
    input  logic [N_CH-1:0]      dut_y,
    output logic [N_IN-1:0]      vec,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERRW-1:0]      err_count,
    output logic [N_IN-1:0]      fail_vec,
    output logic [N_CH-1:0]      fail_mask
);

    stateT           state, stateNext;
    logic            init, adv, dec, check;
    logic            settled, last;
    logic            failSeen;
    logic [N_CH-1:0] mism;
    logic [4:0]      mismCount;

    tt_sweep_seq #(.N_IN(N_IN), .SETTLE(SETTLE)) uSeq (
        .clk    (clk),
        .rst    (rst),
        .init   (init),
        .adv    (adv),
        .dec    (dec),
        .vec    (vec),
        .settled(settled),
        .last   (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        init      = 1'b0;
        adv       = 1'b0;
        dec       = 1'b0;
        check     = 1'b0;
        case (state)
            IDLE, DONE: if (start) begin
                init      = 1'b1;
                stateNext = WAIT;
            end
            WAIT: if (settled) stateNext = CHECK;
                  else         dec       = 1'b1;
            CHECK: begin
                check = 1'b1;
                if (last) stateNext = DONE;
                else begin
                    adv       = 1'b1;
                    stateNext = WAIT;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Case inequality so an undriven or X DUT output is reported, not masked.
    always_comb begin
        mism = '0;
        for (int ch = 0; ch < N_CH; ch++)
            mism[ch] = (dut_y[ch] !== exp_tt[ch*VECS + int'(vec)]);
    end

    assign mismCount = popcount(16'(mism));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
            fail_vec  <= '0;
            fail_mask <= '0;
            failSeen  <= 1'b0;
        end else if (init) begin
            err_count <= '0;
            fail_vec  <= '0;
            fail_mask <= '0;
            failSeen  <= 1'b0;
        end else if (check) begin
            err_count <= err_count + ERRW'(mismCount);
            if ((mism != '0) && !failSeen) begin
                fail_vec  <= vec;
                fail_mask <= mism;
                failSeen  <= 1'b1;
            end
        end
    end

    assign busy = (state == WAIT) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: table-driven sweeps, random tables against a
// reference model, reset/restart corner cases, and a SETTLE=0 instance.
module tb_tt_sweep_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 0: N_IN=3, N_CH=2, SETTLE=1
    logic        start0 = 1'b0;
    logic [15:0] expTt = 16'h0;
    logic [15:0] dutTt = 16'h0;
    logic [1:0]  dutY0;
    logic [2:0]  vec0, failVec0;
    logic [1:0]  failMask0;
    logic [4:0]  errCount0;
    logic        busy0, done0, pass0;

    assign dutY0 = {dutTt[8 + int'(vec0)], dutTt[int'(vec0)]};

    tt_sweep_checker #(.N_IN(3), .N_CH(2), .SETTLE(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .exp_tt(expTt), .dut_y(dutY0),
        .vec(vec0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(errCount0), .fail_vec(failVec0), .fail_mask(failMask0)
    );

    // Instance 1: SETTLE=0, channel 0 of the DUT inverted
    logic        start1 = 1'b0;
    logic [15:0] expTt1 = 16'hE880;
    logic [1:0]  dutY1;
    logic [2:0]  vec1, failVec1;
    logic [1:0]  failMask1;
    logic [4:0]  errCount1;
    logic        busy1, done1, pass1;

    assign dutY1 = {expTt1[8 + int'(vec1)], ~expTt1[int'(vec1)]};

    tt_sweep_checker #(.N_IN(3), .N_CH(2), .SETTLE(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .exp_tt(expTt1), .dut_y(dutY1),
        .vec(vec1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(errCount1), .fail_vec(failVec1), .fail_mask(failMask1)
    );

    int errors = 0;
    int checks = 0;
    logic [2:0] vecQ[$];

    typedef struct {
        logic [15:0] e;
        logic [15:0] d;
        int          err;
        int          fv;
        int          fm;
        int          ps;
    } vecRec;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int code(input int i);
`ifdef TT_SWEEP_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    // Reference: every vector is visited once, so the total is simply the
    // number of differing table bits; first failure follows sweep order.
    task automatic model(input logic [15:0] e, input logic [15:0] d,
                         output int err, output int fv, output int fm);
        logic [1:0] m;
        int v;
        err = $countones(e ^ d);
        fv = 0;
        fm = 0;
        for (int i = 0; i < 8; i++) begin
            v = code(i);
            m = {e[8+v] ^ d[8+v], e[v] ^ d[v]};
            if (m != 2'b00 && fm == 0) begin
                fv = v;
                fm = int'(m);
            end
        end
    endtask

    task automatic runSweep0(input int midStart, output int cyc);
        vecQ.delete();
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        cyc = 0;
        while (busy0 && cyc < 200) begin
            if (vecQ.size() == 0 || vecQ[$] != vec0) vecQ.push_back(vec0);
            cyc++;
            start0 = (cyc == midStart);
            @(negedge clk);
        end
        start0 = 1'b0;
    endtask

    task automatic sweepCheck(input string name, input logic [15:0] e, input logic [15:0] d,
                              input int midStart, input int err, input int fv,
                              input int fm, input int ps);
        int cyc;
        expTt = e;
        dutTt = d;
        runSweep0(midStart, cyc);
        chk({name, "/cycles"}, cyc, 24);
        chk({name, "/nvec"}, vecQ.size(), 8);
        for (int i = 0; i < 8 && i < vecQ.size(); i++)
            chk($sformatf("%s/vec%0d", name, i), int'(vecQ[i]), code(i));
        chk({name, "/done"}, int'(done0), 1);
        chk({name, "/busy"}, int'(busy0), 0);
        chk({name, "/err"}, int'(errCount0), err);
        chk({name, "/failVec"}, int'(failVec0), fv);
        chk({name, "/failMask"}, int'(failMask0), fm);
        chk({name, "/pass"}, int'(pass0), ps);
    endtask

    task automatic checkZero(input string name);
        chk({name, "/busy"}, int'(busy0), 0);
        chk({name, "/done"}, int'(done0), 0);
        chk({name, "/pass"}, int'(pass0), 0);
        chk({name, "/err"}, int'(errCount0), 0);
        chk({name, "/vec"}, int'(vec0), 0);
        chk({name, "/failVec"}, int'(failVec0), 0);
        chk({name, "/failMask"}, int'(failMask0), 0);
    endtask

    vecRec tbl[4];

    initial begin
        int err, fv, fm, cyc;
        logic [15:0] e, d;

        tbl[0] = '{16'hE880, 16'hE880, 0, 0, 0, 1};
        tbl[1] = '{16'hC880, 16'hE880, 1, 5, 2, 0};
        tbl[2] = '{16'hE881, 16'hE880, 1, 0, 1, 0};
        tbl[3] = '{16'hE880, 16'h177F, 16, 0, 3, 0};

        repeat (2) @(negedge clk);
        checkZero("reset");
        rst = 1'b0;
        @(negedge clk);
        checkZero("idle");

        for (int i = 0; i < 4; i++)
            sweepCheck($sformatf("tbl%0d", i), tbl[i].e, tbl[i].d, -1,
                       tbl[i].err, tbl[i].fv, tbl[i].fm, tbl[i].ps);

        // start while busy is ignored; start from DONE clears and reruns
        sweepCheck("midStart", 16'hC880, 16'hE880, 7, 1, 5, 2, 0);
        sweepCheck("rerun", 16'hE880, 16'hE880, -1, 0, 0, 0, 1);

        // Reset mid-sweep, after vector 0 has already logged an error
        expTt = 16'hE881;
        dutTt = 16'hE880;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (9) @(negedge clk);
        chk("preRst/err", int'(errCount0), 1);
        rst = 1'b1;
        #1;
        checkZero("midRst");
        @(negedge clk);
        rst = 1'b0;
        sweepCheck("afterRst", 16'hE880, 16'hE880, -1, 0, 0, 0, 1);

        // Random tables against the reference model
        for (int r = 0; r < 20; r++) begin
            e = 16'($urandom);
            d = e ^ 16'($urandom & $urandom & $urandom);
            model(e, d, err, fv, fm);
            sweepCheck($sformatf("rand%0d", r), e, d, -1, err, fv, fm, int'(err == 0));
        end

        // SETTLE=0 instance: 16-cycle sweep, channel 0 wrong on every vector
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        cyc = 0;
        while (busy1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        chk("settle0/cycles", cyc, 16);
        chk("settle0/done", int'(done1), 1);
        chk("settle0/err", int'(errCount1), 8);
        chk("settle0/failVec", int'(failVec1), 0);
        chk("settle0/failMask", int'(failMask1), 1);
        chk("settle0/pass", int'(pass1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
